mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multicycle CPU (port C, driven by the control unit's memory strobes and the IorD-selected address) and the program-loader/debug port (port D).
- Converts each requester's level valid into one memory transaction of variable latency. It pulses a per-port done, returns read data, and aborts hung accesses on timeout.
- Provides cpu_stall so the CPU control FSM holds its current state until its access completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, max cycles in ACCESS without m_ready before abort (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
c_valid  input  1  CPU request, held until c_done
c_we  input  1  CPU write (1) / read (0)
c_addr  input  ADDR_W  CPU address
c_wdata  input  DATA_W  CPU write data
c_done  output  1  one-cycle completion pulse, CPU
c_err  output  1  one-cycle pulse with c_done on timeout abort
c_rdata  output  DATA_W  CPU read data, held
d_valid, d_we, d_addr, d_wdata  input  1/1/ADDR_W/DATA_W  loader/debug request, same rules as port C
d_done, d_err  output  1  as port C
d_rdata  output  DATA_W  loader read data, held
m_req  output  1  memory request
m_we  output  1  memory write enable
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
m_rdata  input  DATA_W  memory read data, valid with m_ready
m_ready  input  1  memory completion
cpu_stall  output  1  c_valid & ~c_done
busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset==0): state=IDLE. All registered outputs = 0, including rdata registers. TOUT counter = 0. last_grant = D, so C wins the first tie. m_req drops immediately, without waiting for a clock edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If neither valid: stay.
  - If exactly one valid: grant it.
  - If both valid: grant the port != last_grant (round robin).
  - On grant: latch we/addr/wdata into m_we/m_addr/m_wdata, set m_req=1, record grantee into last_grant, clear TOUT counter, go to ACCESS.
  - The m_* outputs are registered, so m_req rises the cycle after valid is sampled.
- ACCESS:
  - m_req=1; m_we/m_addr/m_wdata are stable and ignore requester changes.
  - m_ready=1: if read, capture m_rdata into the grantee's rdata register. Drop m_req, set grantee done=1, go to RESP.
  - Otherwise: increment counter. When the counter reaches TIMEOUT-1 with no m_ready, abort: drop m_req, set grantee done=1 and err=1, leave rdata unchanged, go to RESP.
- RESP:
  - done/err are high this cycle only.
  - Both valids are ignored; always return to IDLE next cycle. A requester therefore must drop valid after done, or it is re-arbitrated as a new request.
- Latency: valid sampled in cycle N → m_req in N+1. m_ready sampled in cycle M → done in M+1. Minimum is 3 cycles valid-to-done, with m_ready in the first ACCESS cycle.
- m_ready outside ACCESS is ignored.
- Requester drops valid mid-ACCESS: the transaction still completes and done still pulses.
- Non-granted port waits; its valid is held, with no starvation (round robin).
- rdata of each port is held until that port's next successful read. Writes never change rdata.
- cpu_stall is combinational from c_valid and c_done.
- TIMEOUT=1: abort at end of first ACCESS cycle if m_ready=0.

Test Plan:
- Reset: drive reset=0 mid-run with no clock edge → m_req, c_done, d_done, busy = 0 immediately; c_rdata=d_rdata=0.
- CPU read: c_valid=1, c_we=0, c_addr=0x10; m_ready=1 with m_rdata=0xDEADBEEF on 2nd ACCESS cycle → m_addr=0x10, m_we=0, c_done pulses 1 cycle later, c_rdata=0xDEADBEEF held after c_valid drops; cpu_stall high until c_done.
- Debug write: d_valid=1, d_we=1, d_addr=0x200, d_wdata=0x12345678 → m_we=1, m_addr=0x200, m_wdata=0x12345678; d_done pulses; d_rdata unchanged.
- Tie: c_valid and d_valid both 1 after reset, each dropped after its done and re-raised → grant order C, D, C, D; the waiting port's done arrives only after the other's RESP.
- Timeout: TIMEOUT=4, d read with m_ready held 0 → m_req high exactly 4 cycles, then d_done=d_err=1 for one cycle; d_rdata unchanged; next request is served normally.
- Reset mid-ACCESS: assert reset with m_req=1 → m_req=0 asynchronously. After release, a pending c_valid is granted C first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the unified instruction/data memory.
// Turns a held valid from the CPU (C) or loader/debug port (D) into one memory access with timeout.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              c_valid,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_done,
   output logic              c_err,
   output logic [DATA_W-1:0] c_rdata,

   input  logic              d_valid,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,

   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready,

   output logic              cpu_stall,
   output logic              busy
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_lastD;
   logic              r_grantD;
   logic [CNT_W-1:0]  r_tout;
   logic              r_mReq;
   logic              r_mWe;
   logic [ADDR_W-1:0] r_mAddr;
   logic [DATA_W-1:0] r_mWdata;
   logic              r_cDone;
   logic              r_cErr;
   logic [DATA_W-1:0] r_cRdata;
   logic              r_dDone;
   logic              r_dErr;
   logic [DATA_W-1:0] r_dRdata;

   logic              w_anyValid;
   logic              w_pickD;

   // D wins only when C is idle or when C was the last port served.
   assign w_anyValid = c_valid | d_valid;
   assign w_pickD    = d_valid & (~c_valid | ~r_lastD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_lastD  <= 1'b1;
         r_grantD <= 1'b0;
         r_tout   <= '0;
         r_mReq   <= 1'b0;
         r_mWe    <= 1'b0;
         r_mAddr  <= '0;
         r_mWdata <= '0;
         r_cDone  <= 1'b0;
         r_cErr   <= 1'b0;
         r_cRdata <= '0;
         r_dDone  <= 1'b0;
         r_dErr   <= 1'b0;
         r_dRdata <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_anyValid) begin
                  r_grantD <= w_pickD;
                  r_lastD  <= w_pickD;
                  r_mWe    <= w_pickD ? d_we    : c_we;
                  r_mAddr  <= w_pickD ? d_addr  : c_addr;
                  r_mWdata <= w_pickD ? d_wdata : c_wdata;
                  r_mReq   <= 1'b1;
                  r_tout   <= '0;
                  r_state  <= ACCESS;
               end
            end
            ACCESS: begin
               if (m_ready) begin
                  if (!r_mWe) begin
                     if (r_grantD) r_dRdata <= m_rdata;
                     else          r_cRdata <= m_rdata;
                  end
                  r_mReq  <= 1'b0;
                  r_cDone <= ~r_grantD;
                  r_dDone <= r_grantD;
                  r_state <= RESP;
               end else if (r_tout == TOUT_LAST) begin
                  // Hung access: report completion with error, leave read data untouched.
                  r_mReq  <= 1'b0;
                  r_cDone <= ~r_grantD;
                  r_cErr  <= ~r_grantD;
                  r_dDone <= r_grantD;
                  r_dErr  <= r_grantD;
                  r_state <= RESP;
               end else begin
                  r_tout <= r_tout + CNT_W'(1);
               end
            end
            RESP: begin
               r_cDone <= 1'b0;
               r_cErr  <= 1'b0;
               r_dDone <= 1'b0;
               r_dErr  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign m_req     = r_mReq;
   assign m_we      = r_mWe;
   assign m_addr    = r_mAddr;
   assign m_wdata   = r_mWdata;
   assign c_done    = r_cDone;
   assign c_err     = r_cErr;
   assign c_rdata   = r_cRdata;
   assign d_done    = r_dDone;
   assign d_err     = r_dErr;
   assign d_rdata   = r_dRdata;
   assign cpu_stall = c_valid & ~r_cDone;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected transactions checked at grant and done.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        c_valid, c_we;
   logic [31:0] c_addr, c_wdata;
   logic        c_done, c_err;
   logic [31:0] c_rdata;
   logic        d_valid, d_we;
   logic [31:0] d_addr, d_wdata;
   logic        d_done, d_err;
   logic [31:0] d_rdata;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rdata;
   logic        m_ready;
   logic        cpu_stall, busy;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
      .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready),
      .cpu_stall(cpu_stall), .busy(busy)
   );

   typedef struct {
      bit          isD;
      bit          we;
      bit          err;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] modelC, modelD;
   int          nCompared, nMismatched;
   int          readyDelay;
   int          accCnt;
   bit          prevReq;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents as seen by the bench: one fixed word, everything else derived from address.
   function automatic logic [31:0] memFn(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEAD_BEEF;
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit isD, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit willErr);
      exp_t e;
      e.isD = isD; e.we = we; e.err = willErr; e.addr = addr; e.wdata = wdata;
      if (!we && !willErr) begin
         e.rdata = memFn(addr);
         if (isD) modelD = e.rdata; else modelC = e.rdata;
      end else begin
         e.rdata = isD ? modelD : modelC;
      end
      sb.push_back(e);
      if (isD) begin
         d_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         c_valid = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
      end
   endtask

   task automatic waitSignal(input int sel, input int maxCycles, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         case (sel)
            0:       seen = c_done;
            1:       seen = d_done;
            default: seen = m_req;
         endcase
      end
      checkOutput(tag, 64'(seen), 64'd1);
   endtask

   // Memory responder: raises m_ready after readyDelay ACCESS cycles.
   always @(negedge clk) begin
      if (!reset || !m_req) begin
         m_ready = 1'b0;
         accCnt  = 0;
      end else begin
         if (accCnt == readyDelay) begin
            m_ready = 1'b1;
            m_rdata = memFn(m_addr);
         end else begin
            m_ready = 1'b0;
         end
         accCnt++;
      end
   end

   // Scoreboard: the granted access must match the oldest expectation; done pops it.
   always @(negedge clk) begin
      if (!reset) begin
         prevReq = 1'b0;
      end else begin
         if (m_req && !prevReq) begin
            if (sb.size() == 0) begin
               checkOutput("grantNoExpect", 64'(sb.size()), 64'd1);
            end else begin
               checkOutput("grantWe", 64'(m_we), 64'(sb[0].we));
               checkOutput("grantAddr", 64'(m_addr), 64'(sb[0].addr));
               if (sb[0].we) checkOutput("grantWdata", 64'(m_wdata), 64'(sb[0].wdata));
            end
         end
         if (c_done || d_done) begin
            if (sb.size() == 0) begin
               checkOutput("doneNoExpect", 64'(sb.size()), 64'd1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("donePort", 64'({d_done, c_done}), e.isD ? 64'd2 : 64'd1);
               checkOutput("doneErr", 64'({d_err, c_err}), e.err ? (e.isD ? 64'd2 : 64'd1) : 64'd0);
               checkOutput("doneRdata", 64'(e.isD ? d_rdata : c_rdata), 64'(e.rdata));
            end
         end
         prevReq = m_req;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int reqCycles;
      nCompared = 0; nMismatched = 0;
      readyDelay = 0; modelC = '0; modelD = '0; prevReq = 1'b0;
      m_ready = 1'b0; m_rdata = '0;
      c_valid = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      reset = 1'b0;

      // Reset state
      #3;
      checkOutput("rstMreq", 64'(m_req), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstDone", 64'({c_done, d_done}), 64'd0);
      checkOutput("rstRdata", 64'({c_rdata, d_rdata}), 64'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // CPU read, m_ready on second ACCESS cycle
      readyDelay = 1;
      applyStimulus(0, 0, 32'h10, 32'h0, 0);
      #1 checkOutput("cpuStallRaise", 64'(cpu_stall), 64'd1);
      checkOutput("cpuNoEarlyReq", 64'(m_req), 64'd0);
      @(negedge clk);
      checkOutput("cpuReq1", 64'(m_req), 64'd1);
      checkOutput("cpuAddr", 64'(m_addr), 64'h10);
      checkOutput("cpuBusy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("cpuReq2", 64'(m_req), 64'd1);
      checkOutput("cpuNoDoneYet", 64'(c_done), 64'd0);
      checkOutput("cpuStallHeld", 64'(cpu_stall), 64'd1);
      @(negedge clk);
      checkOutput("cpuDone", 64'(c_done), 64'd1);
      checkOutput("cpuStallDrop", 64'(cpu_stall), 64'd0);
      checkOutput("cpuReqDrop", 64'(m_req), 64'd0);
      c_valid = 1'b0;
      @(negedge clk);
      checkOutput("cpuDonePulse", 64'(c_done), 64'd0);
      checkOutput("cpuRdataHeld", 64'(c_rdata), 64'hDEAD_BEEF);
      checkOutput("cpuIdle", 64'(busy), 64'd0);

      // Debug write
      readyDelay = 0;
      applyStimulus(1, 1, 32'h200, 32'h1234_5678, 0);
      waitSignal(1, 10, "dbgWriteWait");
      d_valid = 1'b0;
      @(negedge clk);
      checkOutput("dbgRdataKept", 64'(d_rdata), 64'd0);

      // Simultaneous requests alternate C, D, C, D
      applyStimulus(0, 0, 32'h100, 32'h0, 0);
      applyStimulus(1, 0, 32'h104, 32'h0, 0);
      waitSignal(0, 10, "tieC1Wait");
      c_valid = 1'b0;
      @(negedge clk);
      applyStimulus(0, 0, 32'h108, 32'h0, 0);
      waitSignal(1, 10, "tieD1Wait");
      d_valid = 1'b0;
      @(negedge clk);
      applyStimulus(1, 0, 32'h10C, 32'h0, 0);
      waitSignal(0, 10, "tieC2Wait");
      c_valid = 1'b0;
      waitSignal(1, 10, "tieD2Wait");
      d_valid = 1'b0;
      @(negedge clk);

      // Timeout abort on a debug read
      readyDelay = 1000;
      applyStimulus(1, 0, 32'h300, 32'h0, 1);
      reqCycles = 0;
      for (int i = 0; i < 20 && !d_done; i++) begin
         @(negedge clk);
         if (m_req) reqCycles++;
      end
      checkOutput("toutReqCycles", 64'(reqCycles), 64'd4);
      checkOutput("toutErr", 64'(d_err), 64'd1);
      d_valid = 1'b0;
      @(negedge clk);
      checkOutput("toutRdataKept", 64'(d_rdata), 64'(memFn(32'h10C)));
      readyDelay = 0;
      applyStimulus(1, 0, 32'h304, 32'h0, 0);
      waitSignal(1, 10, "afterToutWait");
      d_valid = 1'b0;
      @(negedge clk);

      // Reset in the middle of an access
      readyDelay = 1000;
      applyStimulus(0, 0, 32'h40, 32'h0, 0);
      waitSignal(2, 10, "rstMidReqWait");
      #2 reset = 1'b0;
      sb.delete();
      modelC = '0; modelD = '0;
      #1;
      checkOutput("midRstMreq", 64'(m_req), 64'd0);
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      checkOutput("midRstRdata", 64'({c_rdata, d_rdata}), 64'd0);
      readyDelay = 0;
      applyStimulus(0, 0, 32'h48, 32'h0, 0);
      applyStimulus(1, 0, 32'h44, 32'h0, 0);
      @(negedge clk);
      reset = 1'b1;
      waitSignal(0, 10, "postRstCWait");
      c_valid = 1'b0;
      waitSignal(1, 10, "postRstDWait");
      d_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      checkOutput("sbDrained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
